// File: rtl/keypad_pkg.sv
// Shared key-code constants and the frame-to-key encoder for the keypad scanner path.
// A frame is the 9-bit pressed snapshot, bit 3*row+col set when that key read closed.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam logic [3:0] KEY_MIN  = 4'd1;
  localparam logic [3:0] KEY_MAX  = 4'd9;
  localparam int         NUM_ROWS = 3;
  localparam int         NUM_COLS = 3;

  // Multi-press and ghosting both show up as more than one bit and are rejected.
  function automatic logic [3:0] encode_frame(input logic [NUM_ROWS*NUM_COLS-1:0] snap);
    logic [3:0] code;
    int         hits;
    code = KEY_NONE;
    hits = 0;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
      if (snap[i]) begin
        hits++;
        code = KEY_MIN + 4'(i);
      end
    end
    return (hits == 1) ? code : KEY_NONE;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Frame-level debounce: commits a key once DEBOUNCE_FRAMES identical frames are seen.
// Outputs are registered, one cycle after the committing frame_valid; no backpressure.
module debounce_filter
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 10
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic       frame_valid,
  input  logic [3:0] frame_key,
  output logic [3:0] key,
  output logic       pressed,
  output logic       press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic [CW-1:0] stable_cnt_q, stable_cnt_d;
  logic          pressed_q, pressed_d;
  logic          pulse_q, pulse_d;
  logic [3:0]    fkey;
  logic [3:0]    committed;

  always_comb begin
    fkey         = (frame_key >= KEY_MIN && frame_key <= KEY_MAX) ? frame_key : KEY_NONE;
    // button keeps its last code after release, so the committed key is NONE while released
    committed    = pressed_q ? key_q : KEY_NONE;
    cand_d       = cand_q;
    stable_cnt_d = stable_cnt_q;
    key_d        = key_q;
    pressed_d    = pressed_q;
    pulse_d      = 1'b0;
    if (frame_valid) begin
      if (fkey == cand_q) begin
        if (stable_cnt_q != CW'(DEBOUNCE_FRAMES)) stable_cnt_d = stable_cnt_q + CW'(1);
      end else begin
        cand_d       = fkey;
        stable_cnt_d = CW'(1);
      end
      if (stable_cnt_d == CW'(DEBOUNCE_FRAMES) && cand_d != committed) begin
        if (cand_d == KEY_NONE) begin
          pressed_d = 1'b0;
        end else begin
          key_d     = cand_d;
          pressed_d = 1'b1;
          pulse_d   = !pressed_q;
        end
      end
    end
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      cand_q       <= KEY_NONE;
      key_q        <= KEY_NONE;
      stable_cnt_q <= '0;
      pressed_q    <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      key_q        <= key_d;
      stable_cnt_q <= stable_cnt_d;
      pressed_q    <= pressed_d;
      pulse_q      <= pulse_d;
    end
  end

  assign key         = key_q;
  assign pressed     = pressed_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/keypad_scanner.sv
// 3x3 keypad row scanner with column synchronisers, per-frame snapshot and debounce.
// Press reaches bstate after DEBOUNCE_FRAMES frames (+ partial frame) + 1 cycle; no backpressure.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 12000,
  parameter int SETTLE          = 8,
  parameter int DEBOUNCE_FRAMES = 10
) (
  input  logic       hwclk,
  input  logic       reset,
  output logic       keypad_r1,
  output logic       keypad_r2,
  output logic       keypad_r3,
  input  logic       keypad_c1,
  input  logic       keypad_c2,
  input  logic       keypad_c3,
  output logic [3:0] button,
  output logic       bstate,
  output logic       press_pulse
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int NB = NUM_ROWS * NUM_COLS;

  logic [1:0]          row_idx_q, row_idx_d;
  logic [SW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [NB-1:0]       snap_q, snap_d;
  logic [NUM_COLS-1:0] col_meta_q, col_meta_d;
  logic [NUM_COLS-1:0] col_sync_q, col_sync_d;
  logic                slot_end;
  logic                frame_valid;
  logic [3:0]          frame_key;
  logic [2:0]          rows_n;

  always_comb begin
    col_meta_d  = {keypad_c3, keypad_c2, keypad_c1};
    col_sync_d  = col_meta_q;
    slot_end    = (slot_cnt_q == SW'(SCAN_DIV - 1));
    frame_valid = slot_end && (row_idx_q == 2'd2);
    frame_key   = encode_frame(snap_q);
    slot_cnt_d  = slot_end ? '0 : slot_cnt_q + SW'(1);
    row_idx_d   = row_idx_q;
    if (slot_end) row_idx_d = (row_idx_q == 2'd2) ? 2'd0 : row_idx_q + 2'd1;
    // +2 covers the synchroniser so the sample reflects this row's settled columns
    snap_d = snap_q;
    if (slot_cnt_q == SW'(SETTLE + 2)) begin
      case (row_idx_q)
        2'd0:    snap_d[2:0] = ~col_sync_q;
        2'd1:    snap_d[5:3] = ~col_sync_q;
        default: snap_d[8:6] = ~col_sync_q;
      endcase
    end
    // Rows float high during reset and row 0 is driven as soon as reset drops
    rows_n = reset ? 3'b111 : ~(3'b001 << row_idx_q);
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      row_idx_q  <= 2'd0;
      slot_cnt_q <= '0;
      snap_q     <= '0;
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      row_idx_q  <= row_idx_d;
      slot_cnt_q <= slot_cnt_d;
      snap_q     <= snap_d;
      col_meta_q <= col_meta_d;
      col_sync_q <= col_sync_d;
    end
  end

  assign keypad_r1 = rows_n[0];
  assign keypad_r2 = rows_n[1];
  assign keypad_r3 = rows_n[2];

  debounce_filter #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .hwclk      (hwclk),
    .reset      (reset),
    .frame_valid(frame_valid),
    .frame_key  (frame_key),
    .key        (button),
    .pressed    (bstate),
    .press_pulse(press_pulse)
  );

endmodule
